// File: rtl/cpu6_dmem_resp.sv
// CPU6 MEM-stage data-memory responder: single-entry request register,
// programmable wait states, one-cycle response pulse with fault reporting.
module cpu6_dmem_resp #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH_LOG2 = 10,
    parameter int              WAIT       = 2,
    parameter logic [XLEN-1:0] BASE       = 'h2000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wstrb,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0]    WAIT_CNT = 4'(WAIT);
    localparam logic [XLEN:0] LIMIT    =
        {1'b0, BASE} + ((XLEN+1)'(1) << (DEPTH_LOG2 + 2));

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic                  write_q;
    logic [XLEN-1:0]       addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [3:0]            wstrb_q;
    logic                  accept;
    logic                  commit;
    logic                  err_c;
    logic [DEPTH_LOG2-1:0] idx;

    logic [XLEN-1:0] mem [1 << DEPTH_LOG2];

    // One-bit-wider limit so a window ending at 2^XLEN cannot wrap to 0.
    assign err_c = (addr_q[1:0] != 2'b00)
                 || (addr_q < BASE)
                 || ({1'b0, addr_q} >= LIMIT);

    // BASE is window-aligned, so subtracting it leaves these bits unchanged.
    assign idx = addr_q[DEPTH_LOG2+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (WAIT_CNT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The edge that leaves RESP commits the access and launches the pulse.
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        accept    = req_valid && req_ready;
        commit    = (state == S_RESP) && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'd0;
        end else if (accept) begin
            cnt     <= WAIT_CNT;
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= commit;
            resp_err   <= commit && err_c;
            resp_rdata <= (commit && !write_q && !err_c) ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && write_q && !err_c) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu6_dmem_resp.sv
// Directed bench for cpu6_dmem_resp: vector table on a WAIT=2 instance,
// hand sequences for reset abort and WAIT=0 back-to-back issue.
module tb_cpu6_dmem_resp;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        req_valid0;
    logic        req_ready0;
    logic        req_write0;
    logic [31:0] req_addr0;
    logic [31:0] req_wdata0;
    logic [3:0]  req_wstrb0;
    logic        resp_valid0;
    logic [31:0] resp_rdata0;
    logic        resp_err0;
    logic        busy0;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vt[16];

    cpu6_dmem_resp #(.WAIT(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    cpu6_dmem_resp #(.WAIT(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_write  (req_write0),
        .req_addr   (req_addr0),
        .req_wdata  (req_wdata0),
        .req_wstrb  (req_wstrb0),
        .resp_valid (resp_valid0),
        .resp_rdata (resp_rdata0),
        .resp_err   (resp_err0),
        .busy       (busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to the WAIT=2 instance and check the response.
    task automatic run_req(input vec_t v, input string nm);
        int n;
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        check({nm, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            check({nm, "_busy"}, {30'd0, busy, req_ready}, 32'd2);
            tick();
            n++;
        end
        if (!resp_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no resp_valid in %0d cycles", nm, n);
        end
        check({nm, "_lat"}, 32'(n), 32'd3);
        check({nm, "_rdata"}, resp_rdata, v.rdata);
        check({nm, "_err"}, 32'(resp_err), 32'(v.err));
        tick();
        check({nm, "_after"}, {resp_rdata[30:0], resp_valid}, 32'd0);
        check({nm, "_after_err"}, 32'(resp_err), 32'd0);
    endtask

    initial begin
        int na;
        int nr;
        int acc[4];
        int rsp[4];
        logic [31:0] rd[4];
        logic [3:0]  re;
        logic        will_acc;
        vec_t        v;

        vt[0]  = '{1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h0000_2010, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_2010, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_2010, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_2006, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[6]  = '{1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vt[7]  = '{1'b1, 32'h0000_3000, 32'h5555_5555, 4'hF, 32'h0, 1'b1};
        vt[8]  = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
        vt[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[10] = '{1'b1, 32'h0000_2FFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0};
        vt[11] = '{1'b0, 32'h0000_2FFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0};
        vt[12] = '{1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[13] = '{1'b1, 32'h0000_2010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
        vt[14] = '{1'b0, 32'h0000_2010, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0};
        vt[15] = '{1'b1, 32'h0000_2008, 32'h0, 4'hF, 32'h0, 1'b0};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        req_valid0 = 1'b0;
        req_write0 = 1'b0;
        req_addr0  = 32'h0;
        req_wdata0 = 32'h0;
        req_wstrb0 = 4'h0;

        repeat (3) tick();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_out", {resp_rdata[29:0], resp_err, resp_valid}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", {29'd0, req_ready, busy, resp_valid}, 32'd4);
        end

        for (int i = 0; i < 16; i++) begin
            run_req(vt[i], $sformatf("vec%0d", i));
        end

        // Store aborted by reset while waiting.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_2008;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;
        tick();
        req_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_rst", {30'd0, req_ready, busy}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_noresp", 32'(resp_valid), 32'd0);
        end
        reset = 1'b1;
        tick();
        v = '{1'b0, 32'h0000_2008, 32'h0, 4'h0, 32'h0, 1'b0};
        run_req(v, "abort_load");

        // WAIT=0: store then load with req_valid held high.
        na = 0;
        nr = 0;
        re = 4'd0;
        req_valid0 = 1'b1;
        req_write0 = 1'b1;
        req_addr0  = 32'h0000_2020;
        req_wdata0 = 32'hA5A5_A5A5;
        req_wstrb0 = 4'hF;
        for (int e = 1; e <= 12; e++) begin
            will_acc = req_valid0 && req_ready0;
            tick();
            if (will_acc && na < 4) begin
                acc[na] = e;
                na++;
                if (na == 1) begin
                    req_write0 = 1'b0;
                    req_wdata0 = 32'h0;
                end else begin
                    req_valid0 = 1'b0;
                end
            end
            if (resp_valid0 && nr < 4) begin
                rsp[nr] = e;
                rd[nr]  = resp_rdata0;
                re[nr]  = resp_err0;
                nr++;
            end
        end
        check("b2b_nacc", 32'(na), 32'd2);
        check("b2b_nresp", 32'(nr), 32'd2);
        if (na == 2 && nr == 2) begin
            check("b2b_gap", 32'(acc[1] - acc[0]), 32'd2);
            check("b2b_lat0", 32'(rsp[0] - acc[0]), 32'd1);
            check("b2b_lat1", 32'(rsp[1] - acc[1]), 32'd1);
            check("b2b_rdata", rd[1], 32'hA5A5_A5A5);
            check("b2b_err", {30'd0, re[1:0]}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
